// File: rtl/mmp_iddmm_mul_iter.sv
// Iterative unsigned WIDTH x WIDTH multiplier for the IDDMM datapath.
// Each cycle one LIMB x LIMB partial product is added into a 2*WIDTH
// accumulator at limb offset i+j. Mode 1 keeps only the low WIDTH bits
// and skips partial products whose lowest limb lands above the low half.
module mmp_iddmm_mul_iter #(
  parameter int WIDTH = 128,
  parameter int LIMB  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c_out,
  output logic               out_mode
);

  localparam int N  = WIDTH / LIMB;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  // Operands must split into whole limbs; anything else cannot be built.
  generate
    if ((WIDTH % LIMB) != 0) begin : g_bad_limb
      $error("mmp_iddmm_mul_iter: WIDTH must be a multiple of LIMB");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Low-half result: upper WIDTH bits forced to zero.
  function automatic logic [2*WIDTH-1:0] mask_low(
    input logic [2*WIDTH-1:0] v,
    input logic               lo
  );
    mask_low = lo ? {{WIDTH{1'b0}}, v[WIDTH-1:0]} : v;
  endfunction

  // Operand stage: latched limbs and mode of the operation in flight.
  logic [N-1:0][LIMB-1:0] a_p0;
  logic [N-1:0][LIMB-1:0] b_p0;
  logic                   mode_p0;

  // Accumulator stage.
  logic [2*WIDTH-1:0]     acc_p1;

  logic [IW-1:0]          i_q;
  logic [IW-1:0]          j_q;
  logic [IW-1:0]          j_max;
  logic                   row_end;
  logic                   last_term;
  logic                   accept;
  logic [KW-1:0]          k;
  logic [KW-1:0]          k_inc;
  logic [LIMB-1:0]        a_sel;
  logic [LIMB-1:0]        b_sel;
  logic [2*LIMB-1:0]      pp;
  logic [2*N-1:0][LIMB-1:0] addend;

  assign accept    = (state == IDLE) && in_valid;

  // In low mode row i stops at j = N-1-i: higher j only touch the upper half.
  assign j_max     = mode_p0 ? (LAST_IDX - i_q) : LAST_IDX;
  assign row_end   = (j_q == j_max);
  assign last_term = row_end && (i_q == LAST_IDX);

  assign k         = {1'b0, i_q} + {1'b0, j_q};
  assign k_inc     = k + KW'(1);

  assign a_sel     = a_p0[i_q];
  assign b_sel     = b_p0[j_q];

  assign out_mode  = mode_p0;

  // Single LIMB x LIMB multiply, zero-extended so the full product is kept.
  always_comb begin
    pp = {{LIMB{1'b0}}, a_sel} * {{LIMB{1'b0}}, b_sel};
  end

  // Place the partial product at limbs k and k+1; a limb-select mux, not a shifter.
  always_comb begin
    addend = '0;
    for (int m = 0; m < 2 * N; m++) begin
      if (k == KW'(m)) begin
        addend[m] = pp[LIMB-1:0];
      end else if (k_inc == KW'(m)) begin
        addend[m] = pp[2*LIMB-1:LIMB];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake/result outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    c_out     = '0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last_term) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        c_out     = mask_low(acc_p1, mode_p0);
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Limb indices and latched mode: j walks a row, i advances per row.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q     <= '0;
      j_q     <= '0;
      mode_p0 <= 1'b0;
    end else if (accept) begin
      i_q     <= '0;
      j_q     <= '0;
      mode_p0 <= mode;
    end else if (state == CALC) begin
      if (row_end) begin
        j_q <= '0;
        if (!last_term) begin
          i_q <= i_q + 1'b1;
        end
      end else begin
        j_q <= j_q + 1'b1;
      end
    end
  end

  // Operand capture and accumulation; the result is only visible in DONE.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= a_in;
      b_p0   <= b_in;
      acc_p1 <= '0;
    end else if (state == CALC) begin
      acc_p1 <= acc_p1 + addend;
    end
  end

endmodule

// File: tb/tb_mmp_iddmm_mul_iter.sv
// Scoreboard bench for mmp_iddmm_mul_iter: default 128/32 instance plus a 64/64 variant.
`timescale 1ns/1ps
module tb_mmp_iddmm_mul_iter;

  localparam int P_FULL = 16;
  localparam int P_LOW  = 10;
  localparam logic [255:0] CORNER_FULL =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_00000001;

  logic         clk = 1'b0;
  logic         rst;
  int           cyc = 0;

  logic         in_valid, in_ready, mode, out_valid, out_ready, out_mode;
  logic [127:0] a_in, b_in;
  logic [255:0] c_out;

  logic         in_valid2, in_ready2, mode2, out_valid2, out_ready2, out_mode2;
  logic [63:0]  a2, b2;
  logic [127:0] c_out2;

  typedef struct {
    logic [255:0] c;
    logic         m;
    int           t;
    int           p;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmp_iddmm_mul_iter #(.WIDTH(128), .LIMB(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .c_out(c_out), .out_mode(out_mode)
  );

  mmp_iddmm_mul_iter #(.WIDTH(64), .LIMB(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .mode(mode2),
    .a_in(a2), .b_in(b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .c_out(c_out2), .out_mode(out_mode2)
  );

  // Reference: plain wide multiplication, optionally reduced mod 2^WIDTH.
  function automatic logic [255:0] ref128(input logic [127:0] a, input logic [127:0] b,
                                          input logic m);
    logic [255:0] p;
    p = {128'b0, a} * {128'b0, b};
    return m ? {128'b0, p[127:0]} : p;
  endfunction

  function automatic logic [255:0] ref64(input logic [63:0] a, input logic [63:0] b,
                                         input logic m);
    logic [127:0] p;
    p = {64'b0, a} * {64'b0, b};
    return m ? {192'b0, p[63:0]} : {128'b0, p};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Offer operands to the 128-bit instance until accepted; queue the expectation.
  task automatic issue1(input logic [127:0] a, input logic [127:0] b, input logic m,
                        input logic [255:0] expc, input logic rnd, output int waited);
    exp_t e;
    waited   = 0;
    a_in     = a;
    b_in     = b;
    mode     = m;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      waited++;
      if (waited > 300) begin
        check1("accept_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    e.c = expc;
    e.m = m;
    e.t = cyc + 1;
    e.p = m ? P_LOW : P_FULL;
    sb1.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_in     = rand128();
    b_in     = rand128();
    mode     = ~m;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue2(input logic [63:0] a, input logic [63:0] b, input logic m,
                        input logic [255:0] expc);
    exp_t e;
    int   waited;
    waited    = 0;
    a2        = a;
    b2        = b;
    mode2     = m;
    in_valid2 = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready2 === 1'b1) break;
      waited++;
      if (waited > 50) begin
        check1("w64_accept_timeout", 1'b0, 1'b1);
        in_valid2 = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    e.c = expc;
    e.m = m;
    e.t = cyc + 1;
    e.p = 1;
    sb2.push_back(e);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    a2        = {$urandom(), $urandom()};
    b2        = {$urandom(), $urandom()};
    mode2     = ~m;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb1.size() != 0 || sb2.size() != 0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checkn("drain_pending", sb1.size() + sb2.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor for the 128-bit instance: new result, held result, and release.
  initial begin : mon1
    exp_t e;
    logic held;
    logic drop;
    held = 1'b0;
    drop = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        held = 1'b0;
        drop = 1'b0;
      end else if (drop) begin
        check1("out_valid_drop", out_valid, 1'b0);
        drop = 1'b0;
      end else if (out_valid === 1'b1) begin
        if (!held) begin
          if (sb1.size() == 0) begin
            check1("unexpected_result", 1'b1, 1'b0);
            e.c = '0;
            e.m = 1'b0;
          end else begin
            e = sb1.pop_front();
            check("c_out", c_out, e.c);
            check1("out_mode", out_mode, e.m);
            checkn("latency", cyc - e.t, e.p);
          end
          held = 1'b1;
        end else begin
          check("c_out_held", c_out, e.c);
          check1("out_mode_held", out_mode, e.m);
        end
        if (out_ready === 1'b1) begin
          held = 1'b0;
          drop = 1'b1;
        end
      end
    end
  end

  // Monitor for the 64-bit instance (consumer always ready).
  initial begin : mon2
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && out_valid2 === 1'b1) begin
        if (sb2.size() == 0) begin
          check1("w64_unexpected_result", 1'b1, 1'b0);
        end else begin
          e = sb2.pop_front();
          check("w64_c_out", {128'b0, c_out2}, e.c);
          check1("w64_out_mode", out_mode2, e.m);
          checkn("w64_latency", cyc - e.t, e.p);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d results pending", sb1.size() + sb2.size());
    $fatal(1, "watchdog");
  end

  initial begin : drv
    int           w;
    int           sel;
    logic [127:0] ra, rb;
    logic [63:0]  ra2, rb2;
    logic         rm;

    rst        = 1'b1;
    in_valid   = 1'b0;
    mode       = 1'b0;
    a_in       = '0;
    b_in       = '0;
    out_ready  = 1'b1;
    in_valid2  = 1'b0;
    mode2      = 1'b0;
    a2         = '0;
    b2         = '0;
    out_ready2 = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_c_out", c_out, '0);
    check1("rst_out_mode", out_mode, 1'b0);
    @(posedge clk); #1;

    // All-ones corners in both modes.
    issue1('1, '1, 1'b0, CORNER_FULL, 1'b0, w);
    issue1('1, '1, 1'b1, 256'd1, 1'b0, w);

    // Random regression with random consumer back-pressure.
    for (int t = 0; t < 1000; t++) begin
      ra  = rand128();
      rb  = rand128();
      rm  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 15));
      if (sel == 0) ra = '1;
      if (sel == 1) rb = '0;
      if (sel == 2) ra = 128'd1;
      if (sel == 3) rb = {96'b0, 32'hFFFFFFFF};
      issue1(ra, rb, rm, ref128(ra, rb, rm), 1'b1, w);
    end
    out_ready = 1'b1;
    drain();

    // Held result while the producer wiggles its inputs.
    out_ready = 1'b0;
    ra = rand128();
    rb = rand128();
    issue1(ra, rb, 1'b0, ref128(ra, rb, 1'b0), 1'b0, w);
    w = 0;
    while (out_valid !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check1("bp_reached_done", out_valid, 1'b1);
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      a_in     = rand128();
      b_in     = rand128();
      mode     = ~mode;
      in_valid = ~in_valid;
      @(negedge clk);
      check1("bp_in_ready", in_ready, 1'b0);
      check1("bp_out_valid", out_valid, 1'b1);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    ra = rand128();
    rb = rand128();
    issue1(ra, rb, 1'b1, ref128(ra, rb, 1'b1), 1'b0, w);
    checkn("bp_next_accept_wait", w, 0);
    drain();

    // Reset during the seventh CALC cycle discards the operation.
    ra = rand128();
    rb = rand128();
    issue1(ra, rb, 1'b1, ref128(ra, rb, 1'b1), 1'b0, w);
    void'(sb1.pop_back());
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("midrst_out_valid", out_valid, 1'b0);
    check("midrst_c_out", c_out, '0);
    check1("midrst_in_ready", in_ready, 1'b1);
    check1("midrst_out_mode", out_mode, 1'b0);

    // Reset coinciding with in_valid: operands are not taken.
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    a_in     = 128'd7;
    b_in     = 128'd9;
    mode     = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check1("rst_vs_valid_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    issue1(128'd3, 128'd5, 1'b0, 256'd15, 1'b0, w);
    drain();

    // Single-limb variant.
    issue2(64'hFFFFFFFF_FFFFFFFF, 64'd2, 1'b0, 256'h1_FFFFFFFF_FFFFFFFE);
    issue2(64'hFFFFFFFF_FFFFFFFF, 64'd2, 1'b1, 256'hFFFFFFFF_FFFFFFFE);
    for (int t = 0; t < 30; t++) begin
      ra2 = {$urandom(), $urandom()};
      rb2 = {$urandom(), $urandom()};
      rm  = 1'($urandom_range(0, 1));
      issue2(ra2, rb2, rm, ref64(ra2, rb2, rm));
    end
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmp_iddmm_mul_iter.md
Name: mmp_iddmm_mul_iter

Overview:
- Parametrised, area-reduced successor to the fixed 128x128 IDDMM multiplier.
- Computes an unsigned WIDTH x WIDTH product iteratively, one LIMB x LIMB partial product per cycle, into a 2*WIDTH accumulator.
- Valid/ready handshakes on both the operand and result sides.
- Run-time mode selects the full product or the low half only. The low-half mode serves the Montgomery q-digit step and skips partial products that cannot affect the low half.

Parameters:
- WIDTH, 128: operand width in bits. Must be a multiple of LIMB.
- LIMB, 32: partial-product limb width in bits; one LIMB x LIMB multiply per cycle.
- N (localparam), WIDTH/LIMB: limb count.

Ports:
- clk  input  1: clock, all logic on posedge.
- rst  input  1: synchronous, active-high reset.
- in_valid  input  1: operands and mode valid.
- in_ready  output  1: block can accept operands.
- mode  input  1: 0 = full product; 1 = low half only, result mod 2^WIDTH.
- a_in  input  WIDTH: multiplicand, unsigned.
- b_in  input  WIDTH: multiplier, unsigned.
- out_valid  output  1: result valid.
- out_ready  input  1: consumer accepts result.
- c_out  output  2*WIDTH: product.
- out_mode  output  1: mode latched with the operands of the current result.

Behaviour:
- One clock domain; reset is synchronous and active-high on rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, c_out=0, out_mode=0, internal i=j=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a_in, b_in and mode; clear accumulator; i=0, j=0; go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle: acc <= acc + (a_limb[i]*b_limb[j]) << (LIMB*(i+j)), computed at 2*WIDTH bits. No overflow is possible, because partial sums never exceed the final product.
  - Full mode: j steps 0..N-1, then j=0 and i++. Ends after the term with i=N-1, j=N-1. P = N*N cycles.
  - Low mode: j steps 0..N-1-i, then j=0 and i++. Ends after the term with i=N-1, j=0. P = N*(N+1)/2 cycles.
  - After the last term: go to DONE.
- DONE:
  - out_valid=1.
  - c_out = acc in full mode. In low mode, c_out = {WIDTH zeros, acc[WIDTH-1:0]}, so upper bits are forced to 0.
  - Hold c_out and out_mode stable while out_ready=0.
  - On out_ready: out_valid drops next cycle; go to IDLE.
- Latency: out_valid is high P cycles after the accepting edge. Both handshakes are sampled at posedge as valid&&ready.
- Throughput: in_ready is high only in IDLE, giving one operation per P+2 cycles minimum. Operands offered during CALC or DONE are not accepted and must be held by the producer.
- In-flight changes: a_in, b_in and mode changing after acceptance do not affect the current result.
- Degenerate case N=1 (LIMB=WIDTH): P=1 in both modes; low mode still masks the upper half.
- Zero operands: still take the full P cycles. No early exit.
- Reset mid-operation: rst in any state returns to IDLE with all outputs at reset values next edge. The partial result is discarded and no out_valid pulse is produced.
- rst together with in_valid: reset wins and the operands are not accepted.
- Out-of-range parameters: WIDTH%LIMB != 0 is illegal; elaboration must fail via a generate-time check.
- Implementation target: one LIMB x LIMB multiplier (DSP-mappable) plus a 2*WIDTH adder. The shift is realised by limb-aligned addition into the accumulator, not a barrel shifter.

Test Plan:
- Full-mode corner, WIDTH=128, LIMB=32: a=b=2^128-1, mode=0 -> out_valid exactly 16 cycles after acceptance. c_out = 0xFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_00000001, out_mode=0.
- Low-mode corner: same operands, mode=1 -> out_valid after 10 cycles, c_out=1 (upper 128 bits zero), out_mode=1.
- Random regression: 1000 random a, b and mode vs. a reference model -> c_out = a*b (mode 0) or (a*b) mod 2^128 (mode 1). Cycle counts 16 / 10.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE while toggling a_in, b_in and in_valid -> c_out stable, in_ready=0, no new acceptance. After out_ready, IDLE next cycle and the next operands accepted on the following edge.
- Reset mid-calc: assert rst for 1 cycle at CALC cycle 7 -> next cycle out_valid=0, c_out=0, in_ready=1. A new operation a=3, b=5 then yields c_out=15.
- Parameter variant WIDTH=64, LIMB=64: a=2^64-1, b=2 -> full: c_out=0x1_FFFFFFFF_FFFFFFFE after 1 cycle. Low: c_out=0xFFFFFFFF_FFFFFFFE after 1 cycle.
